// File: rtl/voice_alloc_if.sv
// Bus between the keyboard/tick side and the voice allocator.
// The master drives keys and sample_tick; the slave returns per-voice NCO controls.
interface voice_alloc_if #(
    parameter int NUM_VOICES = 4
);
    logic                       sample_tick;
    logic [11:0]                keys;
    logic [NUM_VOICES*32-1:0]   voice_inc;
    logic [NUM_VOICES-1:0]      voice_mute;
    logic [NUM_VOICES*4-1:0]    voice_key;
    logic                       busy;
    logic                       steal_event;

    modport master (
        output sample_tick, keys,
        input  voice_inc, voice_mute, voice_key, busy, steal_event
    );

    modport slave (
        input  sample_tick, keys,
        output voice_inc, voice_mute, voice_key, busy, steal_event
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic key-to-voice scheduler: 12 keys onto NUM_VOICES NCO voices with oldest-voice stealing.
// Per-voice increment/mute/key outputs are refreshed only on sample_tick.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input logic          clk,
    input logic          rst,
    voice_alloc_if.slave bus
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    // Q5.27 phase increments for C4..B4 at 48 kHz with a 32x oscillator multiple.
    function automatic logic [31:0] inc_lut(input logic [3:0] k);
        case (k)
            4'd0:    inc_lut = 32'h016534C3;
            4'd1:    inc_lut = 32'h017A725A;
            4'd2:    inc_lut = 32'h0190F347;
            4'd3:    inc_lut = 32'h01A8CAC3;
            4'd4:    inc_lut = 32'h01C20D2F;
            4'd5:    inc_lut = 32'h01DCD01D;
            4'd6:    inc_lut = 32'h01F92A6D;
            4'd7:    inc_lut = 32'h02173456;
            4'd8:    inc_lut = 32'h02370783;
            4'd9:    inc_lut = 32'h0258BF26;
            4'd10:   inc_lut = 32'h027C780B;
            4'd11:   inc_lut = 32'h02A250BA;
            default: inc_lut = 32'h00000000;
        endcase
    endfunction

    state_t                          state_q, state_d;
    logic [3:0]                      idx_q, idx_d;
    logic [11:0]                     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [11:0]                     pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [NUM_VOICES-1:0]           act_q, act_d;
    logic [NUM_VOICES-1:0][3:0]      vkey_q, vkey_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    logic [NUM_VOICES-1:0][31:0]     voice_inc_q, voice_inc_d;
    logic [NUM_VOICES-1:0]           voice_mute_q, voice_mute_d;
    logic [NUM_VOICES-1:0][3:0]      voice_key_q, voice_key_d;
    logic                            busy_q, busy_d;
    logic                            steal_q, steal_d;

    logic [11:0]      rise_s, fall_s;
    logic             k_on_s, k_off_s;
    logic             held_s, free_s, old_s;
    logic [VW-1:0]    held_v_s, free_v_s, old_v_s, tgt_v_s;
    logic [AGE_W-1:0] old_age_s;
    logic             hit_s;

    // Next-state logic: synchroniser, pending edges, scan FSM, voice table and output staging.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_d        = act_q;
        vkey_d       = vkey_q;
        age_d        = age_q;
        steal_d      = 1'b0;
        voice_inc_d  = voice_inc_q;
        voice_mute_d = voice_mute_q;
        voice_key_d  = voice_key_q;
        tgt_v_s      = {VW{1'b0}};

        sync1_d = bus.keys;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_s  = sync2_q & ~prev_q;
        fall_s  = ~sync2_q & prev_q;
        pend_on_d  = pend_on_q;
        pend_off_d = pend_off_q;

        k_on_s  = pend_on_q[idx_q];
        k_off_s = pend_off_q[idx_q];

        // Voice searches for the key under the scan pointer: holder, lowest free, oldest active.
        held_s    = 1'b0;
        held_v_s  = {VW{1'b0}};
        free_s    = 1'b0;
        free_v_s  = {VW{1'b0}};
        old_s     = 1'b0;
        old_v_s   = {VW{1'b0}};
        old_age_s = {AGE_W{1'b0}};
        hit_s     = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            hit_s     = act_q[v] && (vkey_q[v] == idx_q) && !held_s;
            held_v_s  = hit_s ? VW'(v) : held_v_s;
            held_s    = held_s | hit_s;
            hit_s     = !act_q[v] && !free_s;
            free_v_s  = hit_s ? VW'(v) : free_v_s;
            free_s    = free_s | hit_s;
            hit_s     = act_q[v] && (!old_s || (age_q[v] > old_age_s));
            old_v_s   = hit_s ? VW'(v) : old_v_s;
            old_age_s = hit_s ? age_q[v] : old_age_s;
            old_s     = old_s | hit_s;
        end

        case (state_q)
            IDLE: begin
                if ((|pend_on_q) || (|pend_off_q)) begin
                    state_d = SCAN;
                    idx_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (k_on_s && held_s) begin
                    // Re-press of a held key: same voice, age restarts, no reallocation.
                    age_d[held_v_s] = {AGE_W{1'b0}};
                end else if (k_on_s) begin
                    tgt_v_s = free_s ? free_v_s : old_v_s;
                    steal_d = !free_s;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VW'(v) == tgt_v_s) begin
                            act_d[v]  = 1'b1;
                            vkey_d[v] = idx_q;
                            age_d[v]  = {AGE_W{1'b0}};
                        end else if (act_q[v] && (age_q[v] != AGE_MAX)) begin
                            age_d[v] = age_q[v] + {{(AGE_W-1){1'b0}}, 1'b1};
                        end else begin
                            age_d[v] = age_q[v];
                        end
                    end
                end else if (k_off_s && held_s) begin
                    act_d[held_v_s]  = 1'b0;
                    vkey_d[held_v_s] = 4'd0;
                    age_d[held_v_s]  = {AGE_W{1'b0}};
                end else begin
                    act_d = act_q;
                end
                pend_on_d[idx_q]  = 1'b0;
                pend_off_d[idx_q] = 1'b0;
                if (idx_q == 4'd11) begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
        endcase

        // New edges land after the scan clear so an edge in the handling cycle is not lost.
        pend_on_d  = pend_on_d | rise_s;
        pend_off_d = pend_off_d | fall_s;
        busy_d     = (state_d == SCAN);

        if (bus.sample_tick) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_inc_d[v]  = act_q[v] ? inc_lut(vkey_q[v]) : 32'd0;
                voice_mute_d[v] = ~act_q[v];
                voice_key_d[v]  = act_q[v] ? vkey_q[v] : 4'd0;
            end
        end else begin
            voice_inc_d = voice_inc_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            sync1_q      <= 12'd0;
            sync2_q      <= 12'd0;
            prev_q       <= 12'd0;
            pend_on_q    <= 12'd0;
            pend_off_q   <= 12'd0;
            act_q        <= '0;
            vkey_q       <= '0;
            age_q        <= '0;
            voice_inc_q  <= '0;
            voice_mute_q <= '1;
            voice_key_q  <= '0;
            busy_q       <= 1'b0;
            steal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            act_q        <= act_d;
            vkey_q       <= vkey_d;
            age_q        <= age_d;
            voice_inc_q  <= voice_inc_d;
            voice_mute_q <= voice_mute_d;
            voice_key_q  <= voice_key_d;
            busy_q       <= busy_d;
            steal_q      <= steal_d;
        end
    end

    assign bus.voice_inc   = voice_inc_q;
    assign bus.voice_mute  = voice_mute_q;
    assign bus.voice_key   = voice_key_q;
    assign bus.busy        = busy_q;
    assign bus.steal_event = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scenario bench for voice_allocator with hand-computed increments and voice assignments.
module tb_voice_allocator;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   steal_cnt = 0;

    voice_alloc_if #(.NUM_VOICES(4)) bus ();

    voice_allocator #(.NUM_VOICES(4), .AGE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count steal pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.steal_event === 1'b1) steal_cnt <= steal_cnt + 1;
    end

    function automatic logic [31:0] inc_of(input int v);
        return bus.voice_inc[32*v +: 32];
    endfunction

    function automatic logic [3:0] key_of(input int v);
        return bus.voice_key[4*v +: 4];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
    endtask

    task automatic apply_reset();
        bus.keys = 12'd0;
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        int s0;
        rst = 1'b0;
        bus.keys = 12'd0;
        bus.sample_tick = 1'b0;
        cycles(3);
        total_cnt++; if (bus.voice_mute !== 4'b1111) $display("FAIL reset_mute: got %b expected 1111", bus.voice_mute); else pass_cnt++;
        total_cnt++; if (bus.voice_inc !== 128'd0) $display("FAIL reset_inc: got %h expected 0", bus.voice_inc); else pass_cnt++;
        total_cnt++; if (bus.voice_key !== 16'd0) $display("FAIL reset_key: got %h expected 0", bus.voice_key); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.steal_event !== 1'b0) $display("FAIL reset_steal: got %b expected 0", bus.steal_event); else pass_cnt++;
        rst = 1'b1;
        s0 = steal_cnt;
        for (int i = 0; i < 20; i++) begin
            pulse_tick();
            cycles(2);
            total_cnt++; if (bus.voice_mute !== 4'b1111 || bus.voice_inc !== 128'd0 || bus.busy !== 1'b0)
                $display("FAIL idle_tick%0d: got mute=%b inc=%h busy=%b expected 1111/0/0", i, bus.voice_mute, bus.voice_inc, bus.busy);
            else pass_cnt++;
        end
        total_cnt++; if (steal_cnt != s0) $display("FAIL idle_steal: got %0d pulses expected 0", steal_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_single_press();
        apply_reset();
        bus.keys = 12'h200;
        cycles(20);
        total_cnt++; if (bus.voice_mute !== 4'b1111) $display("FAIL pre_tick_mute: got %b expected 1111", bus.voice_mute); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL scan_done_busy: got %b expected 0", bus.busy); else pass_cnt++;
        pulse_tick();
        total_cnt++; if (inc_of(0) !== 32'h0258BF26) $display("FAIL a4_inc: got %h expected 0258bf26", inc_of(0)); else pass_cnt++;
        total_cnt++; if (bus.voice_mute !== 4'b1110) $display("FAIL a4_mute: got %b expected 1110", bus.voice_mute); else pass_cnt++;
        total_cnt++; if (key_of(0) !== 4'd9) $display("FAIL a4_key: got %0d expected 9", key_of(0)); else pass_cnt++;
    endtask

    task automatic test_steal();
        int s0;
        apply_reset();
        s0 = steal_cnt;
        bus.keys = 12'h001; cycles(20);
        bus.keys = 12'h005; cycles(20);
        bus.keys = 12'h015; cycles(20);
        bus.keys = 12'h035; cycles(20);
        pulse_tick();
        total_cnt++; if (key_of(3) !== 4'd5 || inc_of(3) !== 32'h01DCD01D)
            $display("FAIL four_held_v3: got key=%0d inc=%h expected 5/01dcd01d", key_of(3), inc_of(3));
        else pass_cnt++;
        total_cnt++; if (steal_cnt != s0) $display("FAIL four_no_steal: got %0d expected 0", steal_cnt - s0); else pass_cnt++;
        bus.keys = 12'h0B5; cycles(20);
        pulse_tick();
        total_cnt++; if (key_of(0) !== 4'd7 || inc_of(0) !== 32'h02173456)
            $display("FAIL steal_v0: got key=%0d inc=%h expected 7/02173456", key_of(0), inc_of(0));
        else pass_cnt++;
        total_cnt++; if (bus.voice_key !== {4'd5, 4'd4, 4'd2, 4'd7}) $display("FAIL steal_keys: got %h expected 5427", bus.voice_key); else pass_cnt++;
        total_cnt++; if (steal_cnt != s0 + 1) $display("FAIL steal_pulses: got %0d expected 1", steal_cnt - s0); else pass_cnt++;
        bus.keys = 12'h0B4; cycles(20);
        pulse_tick();
        total_cnt++; if (bus.voice_key !== {4'd5, 4'd4, 4'd2, 4'd7} || bus.voice_mute !== 4'b0000)
            $display("FAIL stolen_release: got key=%h mute=%b expected 5427/0000", bus.voice_key, bus.voice_mute);
        else pass_cnt++;
        total_cnt++; if (steal_cnt != s0 + 1) $display("FAIL stolen_release_steal: got %0d expected 1", steal_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        bus.keys = 12'h108; cycles(20);
        pulse_tick();
        total_cnt++; if (key_of(0) !== 4'd3 || key_of(1) !== 4'd8)
            $display("FAIL pair_keys: got %0d,%0d expected 3,8", key_of(0), key_of(1));
        else pass_cnt++;
        total_cnt++; if (inc_of(0) !== 32'h01A8CAC3 || inc_of(1) !== 32'h02370783)
            $display("FAIL pair_inc: got %h,%h expected 01a8cac3,02370783", inc_of(0), inc_of(1));
        else pass_cnt++;
        total_cnt++; if (bus.voice_mute !== 4'b1100) $display("FAIL pair_mute: got %b expected 1100", bus.voice_mute); else pass_cnt++;
        bus.keys = 12'h100; cycles(20);
        total_cnt++; if (bus.voice_mute !== 4'b1100) $display("FAIL release_hidden: got %b expected 1100", bus.voice_mute); else pass_cnt++;
        pulse_tick();
        total_cnt++; if (bus.voice_mute !== 4'b1101 || inc_of(0) !== 32'd0 || key_of(0) !== 4'd0)
            $display("FAIL release_v0: got mute=%b inc=%h key=%0d expected 1101/0/0", bus.voice_mute, inc_of(0), key_of(0));
        else pass_cnt++;
        total_cnt++; if (key_of(1) !== 4'd8) $display("FAIL release_v1: got %0d expected 8", key_of(1)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        bus.keys = 12'h042; cycles(20);
        pulse_tick();
        total_cnt++; if (bus.voice_mute !== 4'b1100) $display("FAIL pre_rst_mute: got %b expected 1100", bus.voice_mute); else pass_cnt++;
        bus.keys = 12'h242;
        for (int i = 0; i < 10 && bus.busy !== 1'b1; i++) cycles(1);
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL scan_start: got busy=%b expected 1 within 10 cycles", bus.busy); else pass_cnt++;
        rst = 1'b0;
        cycles(1);
        total_cnt++; if (bus.voice_mute !== 4'b1111 || bus.voice_inc !== 128'd0 || bus.voice_key !== 16'd0)
            $display("FAIL midscan_rst_out: got mute=%b inc=%h key=%h expected 1111/0/0", bus.voice_mute, bus.voice_inc, bus.voice_key);
        else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0 || bus.steal_event !== 1'b0)
            $display("FAIL midscan_rst_busy: got busy=%b steal=%b expected 0/0", bus.busy, bus.steal_event);
        else pass_cnt++;
        rst = 1'b1;
        cycles(20);
        pulse_tick();
        total_cnt++; if (bus.voice_key !== {4'd0, 4'd9, 4'd6, 4'd1} || bus.voice_mute !== 4'b1000)
            $display("FAIL realloc_keys: got key=%h mute=%b expected 0961/1000", bus.voice_key, bus.voice_mute);
        else pass_cnt++;
        total_cnt++; if (inc_of(0) !== 32'h017A725A || inc_of(1) !== 32'h01F92A6D)
            $display("FAIL realloc_inc: got %h,%h expected 017a725a,01f92a6d", inc_of(0), inc_of(1));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int s0;
        apply_reset();
        bus.keys = 12'h200; cycles(20);
        pulse_tick();
        s0 = steal_cnt;
        bus.keys = 12'h000; cycles(2);
        bus.keys = 12'h200; cycles(25);
        pulse_tick();
        total_cnt++; if (key_of(0) !== 4'd9 || inc_of(0) !== 32'h0258BF26)
            $display("FAIL repress_v0: got key=%0d inc=%h expected 9/0258bf26", key_of(0), inc_of(0));
        else pass_cnt++;
        total_cnt++; if (bus.voice_mute !== 4'b1110) $display("FAIL repress_mute: got %b expected 1110", bus.voice_mute); else pass_cnt++;
        total_cnt++; if (steal_cnt != s0) $display("FAIL repress_steal: got %0d expected 0", steal_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_table_edges();
        apply_reset();
        bus.keys = 12'h801; cycles(20);
        pulse_tick();
        total_cnt++; if (inc_of(0) !== 32'h016534C3 || key_of(0) !== 4'd0)
            $display("FAIL c4: got inc=%h key=%0d expected 016534c3/0", inc_of(0), key_of(0));
        else pass_cnt++;
        total_cnt++; if (inc_of(1) !== 32'h02A250BA || key_of(1) !== 4'd11)
            $display("FAIL b4: got inc=%h key=%0d expected 02a250ba/11", inc_of(1), key_of(1));
        else pass_cnt++;
        total_cnt++; if (bus.voice_mute !== 4'b1100) $display("FAIL edge_mute: got %b expected 1100", bus.voice_mute); else pass_cnt++;
    endtask

    initial begin
        bus.keys = 12'd0;
        bus.sample_tick = 1'b0;
        rst = 1'b0;
        test_reset();
        test_single_press();
        test_steal();
        test_same_cycle();
        test_reset_mid_scan();
        test_back_to_back();
        test_table_edges();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
